// File: rtl/wb_sim_pkg.sv
// Shared constants and types for the Wishbone simulation slave and its bench models.
package wb_sim_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_BURST
  } state_e;

  typedef enum logic [1:0] {
    RS_ACK,
    RS_ERR,
    RS_RTY
  } resp_e;

endpackage

// File: rtl/wb_sim_lfsr.sv
// 16-bit Galois LFSR, free-running every clock out of reset.
module wb_sim_lfsr
  import wb_sim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/wb_sim_slave.sv
// Wishbone B3 slave responder for benches: backing memory, jittered waits,
// incrementing bursts, err/rty injection by address and an ack beat counter.
module wb_sim_slave
  import wb_sim_pkg::*;
#(
  parameter int                 WIDTH   = 16,
  parameter int                 ADDRESS = 25,
  parameter int                 ABITS   = 10,
  parameter int                 WAIT    = 1,
  parameter int                 JITTER  = 0,
  parameter int                 RDMODE  = 0,
  parameter logic [ADDRESS-1:0] ERR_LO  = '0,
  parameter logic [ADDRESS-1:0] ERR_HI  = '0,
  parameter logic [ADDRESS-1:0] RTY_ADR = '1,
  parameter logic [15:0]        SEED    = 16'hACE1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [ADDRESS-1:0]   wb_adr_i,
  input  logic [WIDTH/8-1:0]   wb_sel_i,
  input  logic [WIDTH-1:0]     wb_dat_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [WIDTH-1:0]     wb_dat_o,
  output logic [15:0]          beats_o
);

  localparam int          DEPTH  = 2**ABITS;
  localparam int          NSEL   = WIDTH/8;
  localparam logic [15:0] JMASK  = 16'((32'd1 << JITTER) - 32'd1);
  localparam bit          ERR_EN = (ERR_LO <= ERR_HI);

  // Offset compare keeps the range test free of constant-true bounds when ERR_LO is 0
  function automatic resp_e classify(input logic [ADDRESS-1:0] a);
    if (a == RTY_ADR) return RS_RTY;
    if (ERR_EN && ((a - ERR_LO) <= (ERR_HI - ERR_LO))) return RS_ERR;
    return RS_ACK;
  endfunction

  logic [15:0] lfsr;

  wb_sim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .lfsr  (lfsr)
  );

  state_e             state, nxt;
  logic [15:0]        cnt, cnt_ld;
  logic               we_q;
  logic [NSEL-1:0]    sel_q;
  logic [WIDTH-1:0]   dat_q;
  logic [ADDRESS-1:0] adr_q;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               req, resp_en, beat_ok, b_we;
  logic [NSEL-1:0]    b_sel;
  logic [WIDTH-1:0]   b_dat;
  resp_e              kind;

  assign req     = wb_cyc_i & wb_stb_i;
  assign cnt_ld  = 16'(WAIT) + (lfsr & JMASK);
  assign kind    = classify(adr_q);
  assign beat_ok = resp_en && (kind == RS_ACK);
  // Burst beats take write data live from the bus; the first beat uses the latched copy
  assign b_we    = (state == ST_BURST) ? wb_we_i  : we_q;
  assign b_sel   = (state == ST_BURST) ? wb_sel_i : sel_q;
  assign b_dat   = (state == ST_BURST) ? wb_dat_i : dat_q;

  always_comb begin
    nxt     = state;
    resp_en = 1'b0;
    case (state)
      ST_IDLE:  if (req) nxt = (cnt_ld == 16'd0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!wb_cyc_i)          nxt = ST_IDLE;
        else if (cnt == 16'd1)  nxt = ST_RESP;
      end
      ST_RESP: begin
        nxt = ST_IDLE;
        if (wb_cyc_i) begin
          resp_en = 1'b1;
          if (kind == RS_ACK && wb_cti_i == CTI_INCR && req) nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!req) nxt = ST_IDLE;
        else begin
          resp_en = 1'b1;
          if (kind != RS_ACK || wb_cti_i == CTI_EOB) nxt = ST_IDLE;
        end
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      adr_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
      beats_o  <= '0;
    end else begin
      state    <= nxt;
      wb_ack_o <= beat_ok;
      wb_err_o <= resp_en && (kind == RS_ERR);
      wb_rty_o <= resp_en && (kind == RS_RTY);
      if (state == ST_IDLE && req) begin
        cnt   <= cnt_ld;
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
        adr_q <= wb_adr_i;
      end
      if (state == ST_WAIT) cnt <= cnt - 16'd1;
      if (beat_ok) begin
        beats_o <= beats_o + 16'd1;
        adr_q   <= adr_q + 1'b1;
        if (!b_we) wb_dat_o <= (RDMODE != 0) ? WIDTH'(lfsr) : mem[adr_q[ABITS-1:0]];
      end
    end
  end

  // Contents survive reset on purpose: writes acked before a reset stay visible
  always_ff @(posedge wb_clk_i) begin
    if (beat_ok && b_we) begin
      for (int i = 0; i < NSEL; i++)
        if (b_sel[i]) mem[adr_q[ABITS-1:0]][8*i +: 8] <= b_dat[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_wb_sim_slave.sv
// Randomized bench for wb_sim_slave: a zero-wait instance and a jittered instance
// checked against a word/byte memory model with address-range response rules.
module tb_wb_sim_slave;

  localparam logic [24:0] RTY = '1;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, cyc, stb, we, ack, err, rty;
  logic [2:0]  cti   [2];
  logic [24:0] adr   [2];
  logic [1:0]  sel   [2];
  logic [15:0] wdat  [2];
  logic [15:0] rdat  [2];
  logic [15:0] beats [2];

  logic [15:0] mm [2][1024];
  bit          kn [2][1024];
  int          beats_m [2];
  logic [15:0] m_lfsr;
  int          vec = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  wb_sim_slave #(.WAIT(0), .JITTER(0), .ERR_LO(25'd16), .ERR_HI(25'd31)) u_fast (
    .wb_clk_i(clk), .wb_rst_ni(rst_n[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_cti_i(cti[0]), .wb_adr_i(adr[0]), .wb_sel_i(sel[0]),
    .wb_dat_i(wdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]),
    .wb_dat_o(rdat[0]), .beats_o(beats[0]));

  wb_sim_slave #(.WAIT(3), .JITTER(2), .ERR_LO(25'd16), .ERR_HI(25'd31)) u_slow (
    .wb_clk_i(clk), .wb_rst_ni(rst_n[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_cti_i(cti[1]), .wb_adr_i(adr[1]), .wb_sel_i(sel[1]),
    .wb_dat_i(wdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]),
    .wb_dat_o(rdat[1]), .beats_o(beats[1]));

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Reference LFSR for the jittered instance: predicts the extra wait per request
  always @(posedge clk or negedge rst_n[1]) begin
    if (!rst_n[1]) m_lfsr <= 16'hACE1;
    else           m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {rty,err,ack} for a word address
  function automatic logic [2:0] resp_of(input logic [24:0] a);
    if (a == RTY) return 3'b100;
    if (a >= 25'd16 && a <= 25'd31) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [24:0] rand_adr();
    logic [24:0] r;
    case ($urandom_range(0, 9))
      0:       r = RTY;
      1:       r = RTY - 25'($urandom_range(1, 3));
      default: r = 25'($urandom_range(0, 3) * 1024 + $urandom_range(0, 47));
    endcase
    return r;
  endfunction

  task automatic apply(input int d, input bit wr, input logic [24:0] a,
                       input logic [1:0] s, input logic [15:0] wd);
    int i;
    i = int'(a[9:0]);
    beats_m[d]++;
    if (wr) begin
      if (s[0]) mm[d][i][7:0]  = wd[7:0];
      if (s[1]) mm[d][i][15:8] = wd[15:8];
      if (s == 2'b11) kn[d][i] = 1'b1;
    end else if (kn[d][i]) chk("rdata", 32'(rdat[d]), 32'(mm[d][i]));
    chk("beats", 32'(beats[d]), 32'(16'(beats_m[d])));
  endtask

  task automatic drive(input int d, input bit wr, input logic [24:0] a,
                       input logic [1:0] s, input logic [15:0] wd, input logic [2:0] c);
    we[d] = wr; adr[d] = a; sel[d] = s; wdat[d] = wd; cti[d] = c;
    cyc[d] = 1'b1; stb[d] = 1'b1;
  endtask

  task automatic wait_resp(input int d, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(ack[d] | err[d] | rty[d]) && n < 40);
  endtask

  task automatic release_bus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; cti[d] = 3'b000;
    @(posedge clk); #1;
    chk("one_cycle", 32'({rty[d], err[d], ack[d]}), 32'd0);
  endtask

  task automatic single(input int d, input bit wr, input logic [24:0] a,
                        input logic [1:0] s, input logic [15:0] wd);
    int n, lat;
    logic [2:0] r;
    logic [15:0] prev;
    prev = rdat[d];
    lat  = (d == 0) ? 2 : 5 + int'(m_lfsr[1:0]);
    drive(d, wr, a, s, wd, 3'b000);
    wait_resp(d, n);
    chk("latency", 32'(n), 32'(lat));
    if (d == 1) chk("jit_range", 32'(n >= 5 && n <= 8), 32'd1);
    r = resp_of(a);
    chk("resp", 32'({rty[d], err[d], ack[d]}), 32'(r));
    if (r == 3'b001) apply(d, wr, a, s, wd);
    if (r != 3'b001 || wr) chk("dat_hold", 32'(rdat[d]), 32'(prev));
    release_bus(d);
  endtask

  task automatic burst(input bit wr, input logic [24:0] a0, input int len, input bit seq);
    logic [24:0] a;
    logic [15:0] wd, prev;
    logic [1:0]  s;
    logic [2:0]  r;
    int n;
    a = a0;
    for (int k = 0; k < len; k++) begin
      wd   = seq ? 16'(k + 1) : 16'($urandom);
      s    = (k == 0 || seq) ? 2'b11 : 2'($urandom_range(1, 3));
      prev = rdat[0];
      drive(0, wr, a, s, wd, (k == len - 1) ? 3'b111 : 3'b010);
      if (k == 0) begin
        wait_resp(0, n);
        chk("b_latency", 32'(n), 32'd2);
      end else begin
        @(posedge clk); #1;
      end
      r = resp_of(a);
      chk("b_resp", 32'({rty[0], err[0], ack[0]}), 32'(r));
      if (r != 3'b001) begin
        chk("b_hold", 32'(rdat[0]), 32'(prev));
        break;
      end
      apply(0, wr, a, s, wd);
      a = a + 25'd1;
    end
    release_bus(0);
  endtask

  initial begin
    int n;
    rst_n = 2'b00; cyc = 2'b00; stb = 2'b00; we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      cti[d] = 3'b000; adr[d] = '0; sel[d] = 2'b00; wdat[d] = '0; beats_m[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_resp", 32'({rty[d], err[d], ack[d]}), 32'd0);
      chk("rst_dat", 32'(rdat[d]), 32'd0);
      chk("rst_beats", 32'(beats[d]), 32'd0);
    end
    @(negedge clk); rst_n = 2'b11;
    @(posedge clk); #1;

    // Full write, readback, then byte-lane merge
    single(0, 1'b1, 25'd5, 2'b11, 16'h1234);
    single(0, 1'b0, 25'd5, 2'b11, 16'h0000);
    chk("rd_1234", 32'(rdat[0]), 32'h1234);
    chk("beats_2", 32'(beats[0]), 32'd2);
    single(0, 1'b1, 25'd5, 2'b10, 16'hAB00);
    single(0, 1'b0, 25'd5, 2'b11, 16'h0000);
    chk("rd_ab34", 32'(rdat[0]), 32'hAB34);

    // Four-beat incrementing burst, then confirm memory and idle latency
    burst(1'b1, 25'd8, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      single(0, 1'b0, 25'(8 + k), 2'b11, 16'h0000);
      chk("burst_mem", 32'(rdat[0]), 32'(k + 1));
    end

    // err must not touch the aliased word; rty address answers rty only
    single(0, 1'b1, 25'd1044, 2'b11, 16'h5A5A);
    single(0, 1'b1, 25'd20,   2'b11, 16'hFFFF);
    single(0, 1'b0, 25'd1044, 2'b11, 16'h0000);
    chk("err_nowrite", 32'(rdat[0]), 32'h5A5A);
    single(0, 1'b0, RTY, 2'b11, 16'h0000);
    burst(1'b1, RTY - 25'd2, 4, 1'b0);
    burst(1'b1, 25'd14, 4, 1'b0);

    // Reset while an ack is showing: outputs drop at once, the write persists
    drive(0, 1'b1, 25'd7, 2'b11, 16'hC3C3, 3'b000);
    wait_resp(0, n);
    chk("pre_rst_ack", 32'(ack[0]), 32'd1);
    mm[0][7] = 16'hC3C3; kn[0][7] = 1'b1;
    rst_n[0] = 1'b0; #1;
    chk("rst_ack_drop", 32'({rty[0], err[0], ack[0]}), 32'd0);
    chk("rst_beats0", 32'(beats[0]), 32'd0);
    beats_m[0] = 0;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    #2 rst_n[0] = 1'b1;
    @(posedge clk); #1;
    single(0, 1'b0, 25'd7, 2'b11, 16'h0000);
    chk("rst_mem_kept", 32'(rdat[0]), 32'hC3C3);

    // Jittered instance: directed pair, reset during the wait, then random
    single(1, 1'b1, 25'd5, 2'b11, 16'h0F0F);
    single(1, 1'b0, 25'd5, 2'b11, 16'h0000);
    drive(1, 1'b0, 25'd5, 2'b11, 16'h0000, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0; #1;
    chk("rst_wait_resp", 32'({rty[1], err[1], ack[1]}), 32'd0);
    chk("rst_wait_dat", 32'(rdat[1]), 32'd0);
    chk("rst_wait_beats", 32'(beats[1]), 32'd0);
    beats_m[1] = 0;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    single(1, 1'b0, 25'd5, 2'b11, 16'h0000);
    chk("rst_wait_mem", 32'(rdat[1]), 32'h0F0F);
    for (int i = 0; i < 100; i++)
      single(1, 1'($urandom_range(0, 1)), rand_adr(), 2'($urandom_range(1, 3)), 16'($urandom));

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       single(0, 1'b1, rand_adr(), 2'($urandom_range(1, 3)), 16'($urandom));
        1:       single(0, 1'b0, rand_adr(), 2'b11, 16'h0000);
        default: burst(1'($urandom_range(0, 1)), rand_adr(), $urandom_range(1, 5), 1'b0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
